song_reader: RTL
================

// Module: song_reader
// PURPOSE
//  Sequencer that walks the song ROM. Fetches {note, duration} words for the selected song,
//  issues each note to the note player and holds it for `duration` beats. Advances through
//  the song's 32 slots and flags song completion. Sits between the top-level controls and
//  song_rom / note_player.
// PARAMETERS
//  SONG_W  2   song-select width; ROM address = {song, idx}
//  IDX_W   5   note-index width (32 slots per song)
//  NOTE_W  6   note code width; code 0 = rest
//  DUR_W   6   duration width, in beats
// PORTS
//  clk        in   1              system clock
//  reset      in   1              synchronous, active-high
//  play       in   1              1 = run, 0 = pause (freeze in place)
//  song       in   SONG_W         selected song
//  beat       in   1              one-cycle beat tick from beat generator
//  rom_addr   out  SONG_W+IDX_W   address to song_rom (1-cycle read latency)
//  rom_dout   in   NOTE_W+DUR_W   {note, duration} from song_rom
//  new_note   out  1              one-cycle pulse: note/duration valid, start playing
//  note       out  NOTE_W         current note code, held until next new_note
//  duration   out  DUR_W          current duration, held until next new_note
//  playing    out  1              high in PLAY state while play=1
//  song_done  out  1              one-cycle pulse after last slot of song finishes
// BEHAVIOUR
//  - Reset: state=FETCH, idx=0, song_q=song, all outputs 0. rom_addr={song_q,idx}, registered.
//  - FETCH: addr stable. If play=1 -> LOAD, else stay.
//  - LOAD: rom_dout valid. Capture note, dur. dur==0 -> ADVANCE (slot skipped, no new_note).
//    Otherwise beat_cnt<=dur, new_note<=1 -> PLAY.
//  - PLAY: new_note high only in the first PLAY cycle. On beat&play: beat_cnt--.
//    When beat&play&beat_cnt==1 -> ADVANCE. play=0 freezes beat_cnt and state.
//  - ADVANCE: idx==31 -> DONE, idx<=0. Else idx++ -> FETCH.
//  - DONE: song_done=1 for exactly one cycle. Next state depends on the macro (CONFIGURATION).
//  - Latency: FETCH entry at cycle t -> new_note at t+2. A beat in the new_note cycle counts.
//  - Song change: song!=song_q in any state -> next cycle idx=0, song_q=song, state=FETCH,
//    beat_cnt=0, no new_note, no song_done. This takes priority over every other transition.
//  - idx wraps 31->0 only via ADVANCE/DONE. rom_addr never exceeds the selected song's range.
//  - Reset mid-note aborts immediately. note and duration return to 0.
// CONFIGURATION
//  SONG_READER_AUTOLOOP_EN defined:
//    DONE -> FETCH at idx 0; the song repeats indefinitely.
//  SONG_READER_AUTOLOOP_EN undefined:
//    DONE -> STOP. STOP is a hold state: playing=0, no fetches.
//    STOP exits only on reset or a song change.
// STRUCTURE
//  song_pkg: NOTE_W, DUR_W, SONG_W, IDX_W, REST_NOTE=0, state enum
//    {FETCH, LOAD, PLAY, ADVANCE, DONE, STOP}.
//  Sub-module note_timer: loads dur, decrements on beat&en, outputs expire on the last beat.
//  FSM and index logic stay in song_reader.
// TESTING
//  1. Reset, play=1, song=0, ROM[0]={37,2}, beat every 4 cycles
//     -> new_note at cycle 2, note=37; rom_addr=1 after the 2nd beat.
//  2. ROM slot {0,0}
//     -> no new_note for that slot; rom_addr advances within 3 cycles.
//  3. play=0 mid-note for 10 beats, then play=1
//     -> beat_cnt is unchanged across the pause; the note ends after the remaining beats.
//  4. song 0->2 while in PLAY
//     -> next cycle rom_addr=64; new_note 2 cycles later; song_done stays 0.
//  5. All 32 slots dur=1 -> song_done pulses once after slot 31.
//     AUTOLOOP_EN: rom_addr returns to {song,0}.
//     Without AUTOLOOP_EN: state=STOP, no further new_note until a song change.
//  6. Reset asserted in PLAY -> next cycle all outputs 0, rom_addr={song,0}.

Source files
------------

// File: rtl/song_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : song_pkg
//  Brief    : Shared widths, rest code and sequencer state encoding for the
//             song reader slice.
//  Revision : 1.0 - initial release
// ============================================================================
package song_pkg;

    localparam int SONG_W = 2;
    localparam int IDX_W  = 5;
    localparam int NOTE_W = 6;
    localparam int DUR_W  = 6;

    localparam logic [NOTE_W-1:0] REST_NOTE = '0;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PLAY    = 3'd2,
        ST_ADVANCE = 3'd3,
        ST_DONE    = 3'd4,
        ST_STOP    = 3'd5
    } state_t;

endpackage : song_pkg
`default_nettype wire

// File: rtl/song_reader_note_timer.sv
`default_nettype none
// ============================================================================
//  Module   : note_timer
//  Brief    : Beat down-counter for the current note; expire marks the beat
//             on which the note's last beat elapses.
//  Revision : 1.0 - initial release
// ============================================================================
module note_timer #(
    parameter int DUR_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [DUR_W-1:0] dur,
    input  logic             en,
    input  logic             beat,
    output logic             expire
);

    localparam logic [DUR_W-1:0] c_one = {{(DUR_W-1){1'b0}}, 1'b1};

    logic [DUR_W-1:0] r_cnt;
    logic             w_tick;

    assign w_tick = en && beat;
    assign expire = w_tick && (r_cnt == c_one);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= dur;
        end else if (w_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_one;
        end
    end

endmodule : note_timer
`default_nettype wire

// File: rtl/song_reader.sv
`default_nettype none
// ============================================================================
//  Module   : song_reader
//  Brief    : Walks the 32 slots of the selected song in song ROM, issues each
//             note to the player and holds it for its duration in beats.
//             SONG_READER_AUTOLOOP_EN: defined -> song repeats after the last
//             slot; undefined -> reader parks in STOP until reset/song change.
//  Revision : 1.0 - initial release
// ============================================================================
module song_reader
    import song_pkg::*;
#(
    parameter int SONG_W = song_pkg::SONG_W,
    parameter int IDX_W  = song_pkg::IDX_W,
    parameter int NOTE_W = song_pkg::NOTE_W,
    parameter int DUR_W  = song_pkg::DUR_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    play,
    input  logic [SONG_W-1:0]       song,
    input  logic                    beat,
    output logic [SONG_W+IDX_W-1:0] rom_addr,
    input  logic [NOTE_W+DUR_W-1:0] rom_dout,
    output logic                    new_note,
    output logic [NOTE_W-1:0]       note,
    output logic [DUR_W-1:0]        duration,
    output logic                    playing,
    output logic                    song_done
);

    localparam logic [IDX_W-1:0] c_last_idx = '1;
    localparam logic [IDX_W-1:0] c_idx_one  = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t              r_state;
    logic [IDX_W-1:0]    r_idx;
    logic [SONG_W-1:0]   r_song_q;
    logic                r_new_note;
    logic [NOTE_W-1:0]   r_note;
    logic [DUR_W-1:0]    r_duration;
    logic                r_song_done;

    logic [NOTE_W-1:0]   w_rom_note;
    logic [DUR_W-1:0]    w_rom_dur;
    logic                w_song_change;
    logic                w_load;
    logic                w_expire;

    assign w_rom_note    = rom_dout[NOTE_W+DUR_W-1:DUR_W];
    assign w_rom_dur     = rom_dout[DUR_W-1:0];
    assign w_song_change = (song != r_song_q);
    // Zero-duration slots are skipped without touching the timer.
    assign w_load        = (r_state == ST_LOAD) && (w_rom_dur != '0) && !w_song_change;

    note_timer #(
        .DUR_W (DUR_W)
    ) u_note_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_song_change),
        .load   (w_load),
        .dur    (w_rom_dur),
        .en     ((r_state == ST_PLAY) && play),
        .beat   (beat),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_FETCH;
            r_idx       <= '0;
            r_song_q    <= song;
            r_new_note  <= 1'b0;
            r_note      <= '0;
            r_duration  <= '0;
            r_song_done <= 1'b0;
        end else begin
            r_new_note  <= 1'b0;
            r_song_done <= 1'b0;
            if (w_song_change) begin
                r_state  <= ST_FETCH;
                r_idx    <= '0;
                r_song_q <= song;
            end else begin
                case (r_state)
                    ST_FETCH: begin
                        if (play) r_state <= ST_LOAD;
                    end
                    ST_LOAD: begin
                        if (w_rom_dur == '0) begin
                            r_state <= ST_ADVANCE;
                        end else begin
                            r_note     <= w_rom_note;
                            r_duration <= w_rom_dur;
                            r_new_note <= 1'b1;
                            r_state    <= ST_PLAY;
                        end
                    end
                    ST_PLAY: begin
                        if (w_expire) r_state <= ST_ADVANCE;
                    end
                    ST_ADVANCE: begin
                        if (r_idx == c_last_idx) begin
                            r_idx       <= '0;
                            r_song_done <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + c_idx_one;
                            r_state <= ST_FETCH;
                        end
                    end
                    ST_DONE: begin
`ifdef SONG_READER_AUTOLOOP_EN
                        r_state <= ST_FETCH;
`else
                        r_state <= ST_STOP;
`endif
                    end
                    ST_STOP: begin
                        r_state <= ST_STOP;
                    end
                    default: begin
                        r_state <= ST_FETCH;
                    end
                endcase
            end
        end
    end

    assign rom_addr  = {r_song_q, r_idx};
    assign new_note  = r_new_note;
    assign note      = r_note;
    assign duration  = r_duration;
    assign song_done = r_song_done;
    assign playing   = (r_state == ST_PLAY) && play;

endmodule : song_reader
`default_nettype wire
